vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 167 ++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_frame_monitor: measures VGA sync timing, locks onto a matching  |
// | stream and captures the colour at a probe coordinate. Rev 1.0       |
// +--------------------------------------------------------------------+
module vga_frame_monitor #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_START = 144,
  parameter int V_START = 35
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic        horizSync,
  input  logic        vertSync,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [15:0] frame_count,
  output logic        timing_err,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);
  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [10:0] H_ST  = 11'(H_START);
  localparam logic [10:0] V_ST  = 11'(V_START);
  localparam logic [11:0] WDOG  = 12'(2 * H_TOTAL);
  localparam logic [10:0] CMAX  = 11'h7FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  div_q;
  logic        hs_q, vs_q;
  logic [11:0] rgb_q;
  logic [10:0] hcnt_q, vcnt_q;
  logic        pend_v_q, first_q, bad_q;
  logic        locked_q, timing_err_q, probe_valid_q;
  logic [10:0] h_total_q, v_total_q;
  logic [15:0] frame_count_q;
  logic [11:0] probe_rgb_q;

  logic        ce, fall_h, fall_v, boundary;
  logic [10:0] hinc, vinc, hcnt_d;
  logic        h_ok, v_ok, wdog, fail;
  logic [10:0] px, py;
  logic        probe_hit;

  assign ce       = (div_q == 2'd3);
  assign fall_h   = ce & hs_q & ~horizSync;
  assign fall_v   = ce & vs_q & ~vertSync;
  // A vsync edge on the same tick as the hsync edge still marks this line as frame start
  assign boundary = fall_h & (pend_v_q | fall_v);

  assign hinc   = (hcnt_q == CMAX) ? CMAX : hcnt_q + 11'd1;
  assign vinc   = (vcnt_q == CMAX) ? CMAX : vcnt_q + 11'd1;
  assign hcnt_d = fall_h ? 11'd0 : hinc;
  assign h_ok   = (hinc == H_TOT);
  assign v_ok   = (vinc == V_TOT);
  assign wdog   = ce & ~fall_h & (state_q != SEARCH) & ({1'b0, hinc} >= WDOG);

  assign fail = (state_q == MEASURE) ?
                  (wdog | (boundary & ~(~bad_q & h_ok & v_ok))) :
                (state_q == LOCKED) ?
                  (wdog | (fall_h & (~h_ok | (boundary & ~v_ok)))) : 1'b0;

  // Position and colour registers both describe the previous tick's sample
  assign px = hcnt_q - H_ST;
  assign py = vcnt_q - V_ST;
  assign probe_hit = (state_q == LOCKED) &&
                     (hcnt_q >= H_ST) && (px < 11'd640) && (px == {1'b0, probe_x}) &&
                     (vcnt_q >= V_ST) && (py < 11'd480) && (py == {1'b0, probe_y});

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      div_q         <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      rgb_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pend_v_q      <= 1'b0;
      first_q       <= 1'b1;
      bad_q         <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      probe_valid_q <= 1'b0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      frame_count_q <= '0;
      probe_rgb_q   <= '0;
    end else begin
      div_q         <= div_q + 2'd1;
      timing_err_q  <= 1'b0;
      probe_valid_q <= 1'b0;
      if (ce) begin
        hs_q   <= horizSync;
        vs_q   <= vertSync;
        rgb_q  <= {VGA_R, VGA_G, VGA_B};
        hcnt_q <= hcnt_d;
        if (fall_h) begin
          if (first_q) first_q <= 1'b0;
          else         h_total_q <= hinc;
          if (boundary) begin
            v_total_q <= vinc;
            vcnt_q    <= '0;
            pend_v_q  <= 1'b0;
          end else begin
            vcnt_q <= vinc;
          end
        end else if (fall_v) begin
          pend_v_q <= 1'b1;
        end
        if (probe_hit) begin
          probe_rgb_q   <= rgb_q;
          probe_valid_q <= 1'b1;
        end
        if (fail) begin
          state_q      <= SEARCH;
          locked_q     <= 1'b0;
          timing_err_q <= 1'b1;
          first_q      <= 1'b1;
        end else begin
          case (state_q)
            SEARCH: if (boundary) begin
              state_q <= MEASURE;
              bad_q   <= 1'b0;
            end
            MEASURE: begin
              if (boundary) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else if (fall_h && !h_ok) begin
                bad_q <= 1'b1;
              end
            end
            LOCKED: if (boundary) frame_count_q <= frame_count_q + 16'd1;
            default: begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign locked      = locked_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign frame_count = frame_count_q;
  assign timing_err  = timing_err_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// tb_vga_frame_monitor: reduced-size raster (32x10 ticks) driven tick by tick and
// compared against a pixel-tick reference model plus directed expectations.
module tb_vga_frame_monitor;
  localparam int HT = 32, VT = 10, HST = 8, VST = 3, HSW = 4, VSW = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b1, vsync = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic [9:0]  probe_x = '0, probe_y = '0;
  logic        locked, timing_err, probe_valid;
  logic [10:0] h_total, v_total;
  logic [15:0] frame_count;
  logic [11:0] probe_rgb;

  vga_frame_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HST), .V_START(VST)) dut (
    .CLK100MHZ(clk), .reset_n(reset_n), .horizSync(hsync), .vertSync(vsync),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .h_total(h_total), .v_total(v_total), .frame_count(frame_count),
    .timing_err(timing_err), .probe_rgb(probe_rgb), .probe_valid(probe_valid));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int err_seen = 0, pv_seen = 0, last_err_t = -1, cur_t = 0;
  int paint_x = -1, paint_y = -1;
  logic [11:0] paint_c = '0;

  // Reference model: tick position, line position and lock mode (0 search, 1 measure, 2 locked)
  int m_h, m_v, m_mode, e_htot, e_vtot, e_fc;
  bit m_hs, m_vs, m_pend, m_skip, m_bad, e_err, e_pv;
  logic [11:0] m_rgb, e_prgb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 0; e_htot = 0; e_vtot = 0; e_fc = 0;
    m_hs = 0; m_vs = 0; m_pend = 0; m_skip = 1; m_bad = 0; e_err = 0; e_pv = 0;
    m_rgb = '0; e_prgb = '0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [11:0] c);
    bit eh, ev, bnd, bad_now;
    int mh, mv, nh, x, y;
    eh  = m_hs && !hs;
    ev  = m_vs && !vs;
    bnd = eh && (m_pend || ev);
    mh  = (m_h + 1 > 2047) ? 2047 : m_h + 1;
    mv  = (m_v + 1 > 2047) ? 2047 : m_v + 1;
    nh  = eh ? 0 : mh;
    e_err = 0; e_pv = 0; bad_now = 0;
    x = m_h - HST; y = m_v - VST;
    if (m_mode == 2 && x >= 0 && x < 640 && y >= 0 && y < 480 &&
        x == int'(probe_x) && y == int'(probe_y)) begin
      e_pv = 1; e_prgb = m_rgb;
    end
    if (eh) begin
      if (m_skip) m_skip = 0; else e_htot = mh;
      if (bnd) e_vtot = mv;
    end
    if (m_mode != 0 && !eh && nh >= 2 * HT) bad_now = 1;
    else if (eh) begin
      if (m_mode == 0) begin
        if (bnd) begin m_mode = 1; m_bad = 0; end
      end else if (m_mode == 1) begin
        if (mh != HT) m_bad = 1;
        if (bnd) begin
          if (!m_bad && mv == VT) m_mode = 2; else bad_now = 1;
        end
      end else begin
        if (mh != HT || (bnd && mv != VT)) bad_now = 1;
        else if (bnd) e_fc = (e_fc + 1) % 65536;
      end
    end
    if (bad_now) begin m_mode = 0; e_err = 1; m_skip = 1; end
    if (eh) begin
      if (bnd) begin m_v = 0; m_pend = 0; end
      else m_v = mv;
    end else if (ev) m_pend = 1;
    m_h = nh; m_hs = hs; m_vs = vs; m_rgb = c;
  endtask

  // One pixel tick: inputs are set just before the divider's ce edge
  task automatic tick(input bit h, input bit v, input logic [11:0] c);
    hsync = h; vsync = v; {r, g, b} = c;
    @(posedge clk); #1;
    model_step(h, v, c);
    chk("locked", locked, m_mode == 2);
    chk("h_total", h_total, e_htot);
    chk("v_total", v_total, e_vtot);
    chk("frame_count", frame_count, e_fc);
    chk("timing_err", timing_err, e_err);
    chk("probe_valid", probe_valid, e_pv);
    chk("probe_rgb", probe_rgb, e_prgb);
    if (timing_err === 1'b1) begin err_seen++; last_err_t = cur_t; end
    if (probe_valid === 1'b1) pv_seen++;
    @(posedge clk); #1;
    chk("err_width", timing_err, 0);
    chk("pv_width", probe_valid, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic gen_line(input int l, input int len, input bit vs_on);
    logic [11:0] c;
    for (int t = 0; t < len; t++) begin
      cur_t = t;
      c = (l == VST + paint_y && t == HST + paint_x) ? paint_c : 12'($urandom);
      tick(t >= HSW, !(vs_on && l < VSW), c);
    end
  endtask

  task automatic gen_frame(input int bad_l, input int bad_len, input bit vs_on);
    for (int l = 0; l < VT; l++) gen_line(l, (l == bad_l) ? bad_len : HT, vs_on);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_h_total"}, h_total, 0);
    chk({tag, "_v_total"}, v_total, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_timing_err"}, timing_err, 0);
    chk({tag, "_probe_rgb"}, probe_rgb, 0);
    chk({tag, "_probe_valid"}, probe_valid, 0);
  endtask

  task automatic release_reset();
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
  endtask

  typedef struct {
    logic [9:0]  px, py;
    logic [11:0] c, exp_rgb;
    int          exp_pv;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int e0, kind;
    tbl[0] = '{px: 10'd0,   py: 10'd0,   c: 12'hF00, exp_rgb: 12'hF00, exp_pv: 1};
    tbl[1] = '{px: 10'd640, py: 10'd0,   c: 12'hABC, exp_rgb: 12'hF00, exp_pv: 0};
    tbl[2] = '{px: 10'd5,   py: 10'd2,   c: 12'h0A5, exp_rgb: 12'h0A5, exp_pv: 1};
    tbl[3] = '{px: 10'd3,   py: 10'd480, c: 12'h777, exp_rgb: 12'h0A5, exp_pv: 0};
    tbl[4] = '{px: 10'd19,  py: 10'd5,   c: 12'h123, exp_rgb: 12'h123, exp_pv: 1};
    tbl[5] = '{px: 10'd22,  py: 10'd6,   c: 12'hFFF, exp_rgb: 12'hFFF, exp_pv: 1};

    // Reset held with random activity on every input
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); {r, g, b} = 12'($urandom);
      probe_x = 10'($urandom); probe_y = 10'($urandom);
    end
    #1;
    check_cleared("reset_hold");
    probe_x = '0; probe_y = '0;
    release_reset();

    // Ideal source: lock after the second frame boundary
    tick(1'b1, 1'b1, 12'h000);
    gen_frame(-1, HT, 1'b1);
    chk("lock_after_1", locked, 0);
    chk("h_total_meas", h_total, HT);
    gen_frame(-1, HT, 1'b1);
    chk("lock_after_2", locked, 1);
    chk("h_total_lock", h_total, HT);
    chk("v_total_lock", v_total, VT);
    chk("fc_at_lock", frame_count, 0);
    gen_frame(-1, HT, 1'b1);
    chk("fc_plus1", frame_count, 1);

    // Probe table: one locked frame per entry
    foreach (tbl[i]) begin
      probe_x = tbl[i].px; probe_y = tbl[i].py;
      paint_x = int'(tbl[i].px); paint_y = int'(tbl[i].py); paint_c = tbl[i].c;
      e0 = pv_seen;
      gen_frame(-1, HT, 1'b1);
      chk($sformatf("probe_pulses_%0d", i), pv_seen - e0, tbl[i].exp_pv);
      chk($sformatf("probe_rgb_%0d", i), probe_rgb, tbl[i].exp_rgb);
      chk($sformatf("probe_locked_%0d", i), locked, 1);
    end
    paint_x = -1; paint_y = -1;

    // One line one tick too long
    e0 = err_seen;
    gen_frame(4, HT + 1, 1'b1);
    chk("long_line_err", err_seen - e0, 1);
    chk("long_line_unlock", locked, 0);
    gen_frame(-1, HT, 1'b1);
    chk("long_line_relock_1", locked, 0);
    gen_frame(-1, HT, 1'b1);
    chk("long_line_relock_2", locked, 1);
    chk("long_line_err_once", err_seen - e0, 1);

    // hsync stuck high past the watchdog limit
    e0 = err_seen;
    gen_frame(4, 2 * HT + 6, 1'b1);
    chk("wdog_err", err_seen - e0, 1);
    chk("wdog_tick", last_err_t, 2 * HT);
    chk("wdog_unlock", locked, 0);
    gen_frame(-1, HT, 1'b1);
    gen_frame(-1, HT, 1'b1);
    chk("wdog_relock", locked, 1);
    chk("wdog_err_once", err_seen - e0, 1);

    // Asynchronous reset mid-frame while locked
    for (int l = 0; l < 5; l++) gen_line(l, HT, 1'b1);
    reset_n = 1'b0;
    #2;
    check_cleared("async_reset");
    repeat (3) @(posedge clk);
    release_reset();
    e0 = err_seen;
    for (int l = 5; l < VT; l++) gen_line(l, HT, 1'b1);
    gen_frame(-1, HT, 1'b1);
    chk("rst_relock_1", locked, 0);
    gen_frame(-1, HT, 1'b1);
    chk("rst_relock_2", locked, 1);
    chk("rst_fc", frame_count, 0);
    chk("rst_no_err", err_seen - e0, 0);

    // Random frames with occasional timing faults
    for (int f = 0; f < 24; f++) begin
      probe_x = 10'($urandom_range(0, 23)); probe_y = 10'($urandom_range(0, 6));
      paint_x = int'(probe_x); paint_y = int'(probe_y); paint_c = 12'($urandom);
      kind = $urandom_range(0, 7);
      case (kind)
        0: gen_frame($urandom_range(1, VT - 1), HT + 1, 1'b1);
        1: gen_frame($urandom_range(1, VT - 1), HT - 1, 1'b1);
        2: gen_frame($urandom_range(1, VT - 1), 2 * HT + 2, 1'b1);
        3: gen_frame(-1, HT, 1'b0);
        default: gen_frame(-1, HT, 1'b1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
